// File: rtl/divider_16bit_s_if.sv
// Handshake and operand/result bundle for the 16-bit restoring divider.
// The master issues requests and reads results; the divider is the slave.
interface divider_16bit_s_if;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divider_16bit_s.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start
// CALC  | 16 shift/trial-subtract iterations
// DONE  | results valid, done pulses for one cycle
module divider_16bit_s (
  input  logic              clk,
  input  logic              rst,
  divider_16bit_s_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [15:0] r;
  logic [15:0] q;
  logic [15:0] d;
  logic [3:0]  count;

  logic [16:0] r_sh;
  logic [16:0] trial;
  logic [15:0] q_sh;
  logic [15:0] r_next;
  logic [15:0] q_next;

  // Partial remainder always stays below the divisor, so 16 stored bits suffice;
  // the trial difference needs 17 so its sign bit can decide the restore.
  always_comb begin
    r_sh   = {r, q[15]};
    q_sh   = {q[14:0], 1'b0};
    trial  = r_sh + ~{1'b0, d} + 17'd1;
    r_next = r_sh[15:0];
    q_next = q_sh;
    if (!trial[16]) begin
      r_next = trial[15:0];
      q_next = q_sh | 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      r             <= '0;
      q             <= '0;
      d             <= '0;
      count         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor != 16'd0) begin
              d            <= bus.divisor;
              q            <= bus.dividend;
              r            <= '0;
              count        <= '0;
              bus.busy     <= 1'b1;
              bus.div_zero <= 1'b0;
              state        <= CALC;
            end else begin
              bus.quotient  <= 16'hFFFF;
              bus.remainder <= bus.dividend;
              bus.div_zero  <= 1'b1;
              bus.done      <= 1'b1;
              state         <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          q     <= q_next;
          r     <= r_next;
          count <= count + 4'd1;
          if (count == 4'd15) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= q_next;
            bus.remainder <= r_next;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16bit_s.sv
// Directed bench for divider_16bit_s: a queue holds expected results per request,
// popped and compared whenever done pulses.
module tb_divider_16bit_s;

  logic clk = 1'b0;
  logic rst = 1'b1;

  divider_16bit_s_if dif ();

  divider_16bit_s dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int n_pushed   = 0;
  int n_done     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dif.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient", {16'd0, dif.quotient}, {16'd0, e.q});
        check("remainder", {16'd0, dif.remainder}, {16'd0, e.r});
        check("div_zero", {31'd0, dif.div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit expect_it);
    exp_t e;
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    if (expect_it) begin
      if (b == 16'd0) begin
        e.q = 16'hFFFF; e.r = a; e.dz = 1'b1;
      end else begin
        e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end
      exp_q.push_back(e);
      n_pushed++;
    end
  endtask

  // Accept at the next edge, then count edges to done and busy samples on the way.
  // inj >= 0 pulses an extra start (50/5) at that offset, which must be ignored.
  task automatic accept_and_wait(input int exp_off, input int inj);
    int off;
    int bh;
    @(posedge clk); #1;
    dif.start    = 1'b0;
    dif.dividend = 16'($urandom);
    dif.divisor  = 16'($urandom);
    off = 0;
    bh  = 0;
    while (!dif.done && off < 40) begin
      if (dif.busy) bh++;
      if (off == inj) begin
        dif.start = 1'b1; dif.dividend = 16'd50; dif.divisor = 16'd5;
      end
      @(posedge clk); #1;
      dif.start = 1'b0;
      off++;
    end
    check("done_offset", off, exp_off);
    check("busy_cycles", bh, exp_off);
    check("busy_at_done", {31'd0, dif.busy}, 32'd0);
  endtask

  task automatic expect_done_drop();
    @(posedge clk); #1;
    check("done_cleared", {31'd0, dif.done}, 32'd0);
  endtask

  initial begin
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, dif.busy}, 32'd0);
    check("rst_done", {31'd0, dif.done}, 32'd0);
    check("rst_quotient", {16'd0, dif.quotient}, 32'd0);
    check("rst_remainder", {16'd0, dif.remainder}, 32'd0);
    check("rst_div_zero", {31'd0, dif.div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'd100, 16'd7, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();

    issue(16'hFFFF, 16'd1, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();

    issue(16'd5, 16'd0, 1'b1);
    accept_and_wait(0, -1);
    expect_done_drop();
    issue(16'd9, 16'd3, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();

    issue(16'd3, 16'd10, 1'b1);
    accept_and_wait(16, 5);
    expect_done_drop();
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_results_q", {16'd0, dif.quotient}, 32'd0);
    check("ignored_start_results_r", {16'd0, dif.remainder}, 32'd3);

    // Abort mid-calculation with an asynchronous reset between clock edges.
    issue(16'd1000, 16'd3, 1'b0);
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, dif.busy}, 32'd0);
    check("abort_done", {31'd0, dif.done}, 32'd0);
    check("abort_quotient", {16'd0, dif.quotient}, 32'd0);
    check("abort_remainder", {16'd0, dif.remainder}, 32'd0);
    check("abort_div_zero", {31'd0, dif.div_zero}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'd1000, 16'd3, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();

    // Back-to-back: start held during the DONE cycle.
    issue(16'd40000, 16'd123, 1'b1);
    accept_and_wait(16, -1);
    issue(16'd7, 16'd7, 1'b1);
    accept_and_wait(16, -1);
    expect_done_drop();

    repeat (5) @(posedge clk);
    #1;
    check("pending_results", exp_q.size(), 32'd0);
    check("done_pulses", n_done, n_pushed);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
